// File: rtl/accum_pkg.sv
// Shared types for the accumulation zone, router and slot arbiter.
// Slot index, bank mask, row address and bank data live here.
package accum_pkg;

    localparam int ACC_NUM_SLOTS = 2;
    localparam int ACC_NUM_BANKS = 4;
    localparam int ACC_ADDR_W    = 9;
    localparam int ACC_DATA_W    = 64;
    localparam int ACC_SLOT_W    = (ACC_NUM_SLOTS > 1) ? $clog2(ACC_NUM_SLOTS) : 1;

    typedef logic [ACC_SLOT_W-1:0]    slot_idx_t;
    typedef logic [ACC_NUM_BANKS-1:0] bank_mask_t;
    typedef logic [ACC_ADDR_W-1:0]    row_addr_t;
    typedef logic [ACC_DATA_W-1:0]    bank_data_t;

    // Index width that stays legal when there is only one slot.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/accum_rr_arbiter.sv
// Round-robin search with grant lock while the master stalls.
// Pointer advances past the winner only on an accepted handshake.
module accum_rr_arbiter
    import accum_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [N-1:0]  i_req,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_lock_idx;
    logic          r_lock;
    logic [IW-1:0] w_search;
    logic          w_found;
    logic          w_hold;

    always_comb begin
        w_found  = 1'b0;
        w_search = r_ptr;
        for (int k = 0; k < N; k++) begin
            if (!w_found && i_req[wrap_add(int'(r_ptr), k, N)]) begin
                w_found  = 1'b1;
                w_search = IW'(wrap_add(int'(r_ptr), k, N));
            end
        end
    end

    // A stalled grant keeps its slot as long as that slot still requests.
    assign w_hold  = r_lock && i_req[r_lock_idx];
    assign o_valid = |i_req;
    assign o_idx   = w_hold ? r_lock_idx : w_search;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr      <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else if (o_valid && i_ready) begin
            r_ptr      <= IW'(wrap_add(int'(o_idx), 1, N));
            r_lock     <= 1'b0;
        end else begin
            r_lock     <= o_valid;
            r_lock_idx <= o_idx;
        end
    end

endmodule

// File: rtl/accum_slot_arbiter.sv
// Write/read slot arbiter with in-order read-return tag FIFO.
// Define ACCUM_ARB_PERF_EN to add per-slot grant counters.
module accum_slot_arbiter
    import accum_pkg::*;
#(
    parameter int NUM_SLOTS      = 2,
    parameter int NUM_BANKS      = 4,
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_WIDTH     = 64,
    parameter int RD_OUTSTANDING = 4
) (
    input  logic                                        clk,
    input  logic                                        rstn,
    input  logic [NUM_SLOTS-1:0]                        s_wr_valid,
    output logic [NUM_SLOTS-1:0]                        s_wr_ready,
    input  logic [NUM_SLOTS*ADDR_WIDTH-1:0]             s_wr_addr,
    input  logic [NUM_SLOTS*NUM_BANKS-1:0]              s_wr_mask,
    input  logic [NUM_SLOTS-1:0]                        s_accum_en,
    input  logic [NUM_SLOTS*NUM_BANKS*DATA_WIDTH-1:0]   s_wdata,
    input  logic [NUM_SLOTS-1:0]                        s_rd_valid,
    output logic [NUM_SLOTS-1:0]                        s_rd_ready,
    input  logic [NUM_SLOTS*ADDR_WIDTH-1:0]             s_rd_addr,
    input  logic [NUM_SLOTS*NUM_BANKS-1:0]              s_rd_mask,
    output logic [NUM_SLOTS-1:0]                        s_rvalid,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]             s_rdata,
    output logic                                        m_wr_valid,
    input  logic                                        m_wr_ready,
    output logic [ADDR_WIDTH-1:0]                       m_wr_addr,
    output logic [NUM_BANKS-1:0]                        m_wr_mask,
    output logic                                        m_accum_en,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]             m_wdata,
    output logic                                        m_rd_valid,
    input  logic                                        m_rd_ready,
    output logic [ADDR_WIDTH-1:0]                       m_rd_addr,
    output logic [NUM_BANKS-1:0]                        m_rd_mask,
    input  logic                                        m_rvalid,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]             m_rdata,
    output logic                                        err_orphan
`ifdef ACCUM_ARB_PERF_EN
    ,
    output logic [NUM_SLOTS*32-1:0]                     perf_wr_grants,
    output logic [NUM_SLOTS*32-1:0]                     perf_rd_grants
`endif
);

    localparam int IW = idx_w(NUM_SLOTS);
    localparam int FW = $clog2(RD_OUTSTANDING);
    localparam int BW = NUM_BANKS * DATA_WIDTH;

    logic [IW-1:0]        w_wr_idx;
    logic [IW-1:0]        w_rd_idx;
    logic [NUM_SLOTS-1:0] w_rd_req;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [FW:0]          r_cnt;
    logic [FW-1:0]        r_wp;
    logic [FW-1:0]        r_rp;
    logic [IW-1:0]        r_tag [RD_OUTSTANDING];
    logic                 r_orphan;

    accum_rr_arbiter #(.N(NUM_SLOTS), .IW(IW)) u_wr_rr (
        .clk     (clk),
        .rstn    (rstn),
        .i_req   (s_wr_valid),
        .i_ready (m_wr_ready),
        .o_valid (m_wr_valid),
        .o_idx   (w_wr_idx)
    );

    // A full tag FIFO hides every read request, even on a popping cycle.
    assign w_rd_req = s_rd_valid & {NUM_SLOTS{~w_full}};

    accum_rr_arbiter #(.N(NUM_SLOTS), .IW(IW)) u_rd_rr (
        .clk     (clk),
        .rstn    (rstn),
        .i_req   (w_rd_req),
        .i_ready (m_rd_ready),
        .o_valid (m_rd_valid),
        .o_idx   (w_rd_idx)
    );

    assign m_wr_addr  = s_wr_addr[w_wr_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_wr_mask  = s_wr_mask[w_wr_idx*NUM_BANKS +: NUM_BANKS];
    assign m_accum_en = s_accum_en[w_wr_idx];
    assign m_wdata    = s_wdata[w_wr_idx*BW +: BW];
    assign m_rd_addr  = s_rd_addr[w_rd_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_rd_mask  = s_rd_mask[w_rd_idx*NUM_BANKS +: NUM_BANKS];

    assign w_full  = (r_cnt == (FW+1)'(RD_OUTSTANDING));
    assign w_empty = (r_cnt == '0);
    assign w_push  = m_rd_valid && m_rd_ready;
    assign w_pop   = m_rvalid && !w_empty;

    always_comb begin
        s_wr_ready = '0;
        s_rd_ready = '0;
        s_rvalid   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            s_wr_ready[i] = m_wr_valid && m_wr_ready && (w_wr_idx == IW'(i));
            s_rd_ready[i] = w_push && (w_rd_idx == IW'(i));
            s_rvalid[i]   = w_pop && (r_tag[r_rp] == IW'(i));
        end
    end

    assign s_rdata    = m_rdata;
    assign err_orphan = r_orphan;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt    <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_orphan <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
            if (m_rvalid && w_empty) r_orphan <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_tag[r_wp] <= w_rd_idx;
    end

`ifdef ACCUM_ARB_PERF_EN
    logic [31:0] r_perf_wr [NUM_SLOTS];
    logic [31:0] r_perf_rd [NUM_SLOTS];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_perf_wr[i] <= '0;
                r_perf_rd[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (s_wr_ready[i] && r_perf_wr[i] != '1)
                    r_perf_wr[i] <= r_perf_wr[i] + 32'd1;
                if (s_rd_ready[i] && r_perf_rd[i] != '1)
                    r_perf_rd[i] <= r_perf_rd[i] + 32'd1;
            end
        end
    end

    always_comb begin
        perf_wr_grants = '0;
        perf_rd_grants = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            perf_wr_grants[i*32 +: 32] = r_perf_wr[i];
            perf_rd_grants[i*32 +: 32] = r_perf_rd[i];
        end
    end
`endif

endmodule

// File: tb/tb_accum_slot_arbiter.sv
// Directed bench for accum_slot_arbiter with default parameters.
// Covers round-robin, stall lock, tag FIFO limits, orphan and reset.
module tb_accum_slot_arbiter;

    logic         clk;
    logic         rstn;
    logic [1:0]   s_wr_valid;
    logic [1:0]   s_wr_ready;
    logic [17:0]  s_wr_addr;
    logic [7:0]   s_wr_mask;
    logic [1:0]   s_accum_en;
    logic [511:0] s_wdata;
    logic [1:0]   s_rd_valid;
    logic [1:0]   s_rd_ready;
    logic [17:0]  s_rd_addr;
    logic [7:0]   s_rd_mask;
    logic [1:0]   s_rvalid;
    logic [255:0] s_rdata;
    logic         m_wr_valid;
    logic         m_wr_ready;
    logic [8:0]   m_wr_addr;
    logic [3:0]   m_wr_mask;
    logic         m_accum_en;
    logic [255:0] m_wdata;
    logic         m_rd_valid;
    logic         m_rd_ready;
    logic [8:0]   m_rd_addr;
    logic [3:0]   m_rd_mask;
    logic         m_rvalid;
    logic [255:0] m_rdata;
    logic         err_orphan;
`ifdef ACCUM_ARB_PERF_EN
    logic [63:0]  perf_wr_grants;
    logic [63:0]  perf_rd_grants;
`endif

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [255:0] WD0 = {4{64'hA0A0_A0A0_A0A0_A0A0}};
    localparam logic [255:0] WD1 = {4{64'h5B5B_5B5B_5B5B_5B5B}};

    accum_slot_arbiter dut (
        .clk        (clk),
        .rstn       (rstn),
        .s_wr_valid (s_wr_valid),
        .s_wr_ready (s_wr_ready),
        .s_wr_addr  (s_wr_addr),
        .s_wr_mask  (s_wr_mask),
        .s_accum_en (s_accum_en),
        .s_wdata    (s_wdata),
        .s_rd_valid (s_rd_valid),
        .s_rd_ready (s_rd_ready),
        .s_rd_addr  (s_rd_addr),
        .s_rd_mask  (s_rd_mask),
        .s_rvalid   (s_rvalid),
        .s_rdata    (s_rdata),
        .m_wr_valid (m_wr_valid),
        .m_wr_ready (m_wr_ready),
        .m_wr_addr  (m_wr_addr),
        .m_wr_mask  (m_wr_mask),
        .m_accum_en (m_accum_en),
        .m_wdata    (m_wdata),
        .m_rd_valid (m_rd_valid),
        .m_rd_ready (m_rd_ready),
        .m_rd_addr  (m_rd_addr),
        .m_rd_mask  (m_rd_mask),
        .m_rvalid   (m_rvalid),
        .m_rdata    (m_rdata),
        .err_orphan (err_orphan)
`ifdef ACCUM_ARB_PERF_EN
        ,
        .perf_wr_grants (perf_wr_grants),
        .perf_rd_grants (perf_rd_grants)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] rd_seq [4];
        rd_seq = '{2'b01, 2'b10, 2'b10, 2'b01};

        rstn       = 1'b0;
        s_wr_valid = '0;
        s_wr_addr  = {9'h021, 9'h010};
        s_wr_mask  = {4'hA, 4'h5};
        s_accum_en = 2'b10;
        s_wdata    = {WD1, WD0};
        s_rd_valid = '0;
        s_rd_addr  = {9'h15A, 9'h0A5};
        s_rd_mask  = {4'hC, 4'h3};
        m_wr_ready = 1'b0;
        m_rd_ready = 1'b0;
        m_rvalid   = 1'b0;
        m_rdata    = '0;

        smp();
        chk("rst_rvalid", 256'(s_rvalid), 256'(2'b00));
        chk("rst_orphan", 256'(err_orphan), 256'(1'b0));
        chk("rst_m_wr_valid", 256'(m_wr_valid), 256'(1'b0));
        chk("rst_m_rd_valid", 256'(m_rd_valid), 256'(1'b0));
        nxt();
        rstn       = 1'b1;
        m_wr_ready = 1'b1;
        m_rd_ready = 1'b1;

        // Alternating write grants with both slots always requesting
        s_wr_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("rr_wr_addr", 256'(m_wr_addr),
                256'((i % 2 == 1) ? 9'h021 : 9'h010));
            chk("rr_wr_ready", 256'(s_wr_ready),
                256'((i % 2 == 1) ? 2'b10 : 2'b01));
            if (i == 0) begin
                chk("wr_mask0", 256'(m_wr_mask), 256'(4'h5));
                chk("wr_accum0", 256'(m_accum_en), 256'(1'b0));
                chk("wr_data0", m_wdata, WD0);
            end
            if (i == 1) begin
                chk("wr_mask1", 256'(m_wr_mask), 256'(4'hA));
                chk("wr_accum1", 256'(m_accum_en), 256'(1'b1));
                chk("wr_data1", m_wdata, WD1);
            end
            nxt();
        end

        // Stall: slot1 holds the grant even when slot0 joins
        s_wr_valid = 2'b10;
        m_wr_ready = 1'b0;
        smp();
        chk("stall1_addr", 256'(m_wr_addr), 256'(9'h021));
        chk("stall1_ready", 256'(s_wr_ready), 256'(2'b00));
        nxt();
        s_wr_valid = 2'b11;
        smp();
        chk("stall2_addr", 256'(m_wr_addr), 256'(9'h021));
        chk("stall2_ready", 256'(s_wr_ready), 256'(2'b00));
        nxt();
        smp();
        chk("stall3_addr", 256'(m_wr_addr), 256'(9'h021));
        nxt();
        m_wr_ready = 1'b1;
        smp();
        chk("stall_accept", 256'(s_wr_ready), 256'(2'b10));
        chk("stall_accept_addr", 256'(m_wr_addr), 256'(9'h021));
        nxt();
        smp();
        chk("ptr_after_stall", 256'(m_wr_addr), 256'(9'h010));
        chk("ptr_after_stall_rdy", 256'(s_wr_ready), 256'(2'b01));
        nxt();
        s_wr_valid = 2'b00;

        // Four reads fill the tag FIFO
        for (int i = 0; i < 4; i++) begin
            s_rd_valid = rd_seq[i];
            smp();
            chk("fill_rd_ready", 256'(s_rd_ready), 256'(rd_seq[i]));
            chk("fill_rd_addr", 256'(m_rd_addr),
                256'((rd_seq[i] == 2'b10) ? 9'h15A : 9'h0A5));
            nxt();
        end
        s_rd_valid = 2'b11;
        smp();
        chk("full_m_rd_valid", 256'(m_rd_valid), 256'(1'b0));
        chk("full_rd_ready", 256'(s_rd_ready), 256'(2'b00));
        nxt();
        s_rd_valid = 2'b00;
        m_rvalid   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_rdata = 256'(i + 1) * 256'h1234_5678_9ABC;
            smp();
            chk("ret_order", 256'(s_rvalid), 256'(rd_seq[i]));
            chk("ret_data", s_rdata, 256'(i + 1) * 256'h1234_5678_9ABC);
            nxt();
        end
        m_rvalid = 1'b0;
        smp();
        chk("no_orphan_yet", 256'(err_orphan), 256'(1'b0));
        nxt();

        // Refill, then a pop and a new read in the same cycle
        s_rd_valid = 2'b01;
        repeat (4) nxt();
        s_rd_valid = 2'b10;
        m_rvalid   = 1'b1;
        smp();
        chk("popfull_m_rd_valid", 256'(m_rd_valid), 256'(1'b0));
        chk("popfull_rd_ready", 256'(s_rd_ready), 256'(2'b00));
        chk("popfull_rvalid", 256'(s_rvalid), 256'(2'b01));
        nxt();
        m_rvalid = 1'b0;
        smp();
        chk("next_accept", 256'(s_rd_ready), 256'(2'b10));
        nxt();
        s_rd_valid = 2'b01;
        smp();
        chk("full_again", 256'(m_rd_valid), 256'(1'b0));
        nxt();
        s_rd_valid = 2'b00;

        // Write pointer sits at 1; reset with tags outstanding
        s_wr_valid = 2'b11;
        m_wr_ready = 1'b0;
        smp();
        chk("pre_rst_ptr", 256'(m_wr_addr), 256'(9'h021));
        rstn     = 1'b0;
        m_rvalid = 1'b1;
        #2;
        chk("in_rst_rvalid", 256'(s_rvalid), 256'(2'b00));
        chk("in_rst_orphan", 256'(err_orphan), 256'(1'b0));
        nxt();
        nxt();
        rstn       = 1'b1;
        m_rvalid   = 1'b0;
        m_wr_ready = 1'b1;
        smp();
        chk("post_rst_ptr", 256'(m_wr_addr), 256'(9'h010));
        chk("post_rst_ready", 256'(s_wr_ready), 256'(2'b01));
`ifdef ACCUM_ARB_PERF_EN
        chk("perf_wr_zero", 256'(perf_wr_grants), 256'(0));
        chk("perf_rd_zero", 256'(perf_rd_grants), 256'(0));
`endif
        nxt();
        s_wr_valid = 2'b00;

        // Discarded tags: a late return is an orphan
        m_rvalid = 1'b1;
        smp();
        chk("orphan_rvalid", 256'(s_rvalid), 256'(2'b00));
        nxt();
        m_rvalid = 1'b0;
        smp();
        chk("orphan_set", 256'(err_orphan), 256'(1'b1));
        nxt();
        s_rd_valid = 2'b11;
        smp();
        chk("post_rst_rd_ptr", 256'(s_rd_ready), 256'(2'b01));
        nxt();
        s_rd_valid = 2'b00;
        m_rvalid   = 1'b1;
        smp();
        chk("valid_ret", 256'(s_rvalid), 256'(2'b01));
        nxt();
        m_rvalid = 1'b0;
        nxt();
        smp();
        chk("orphan_sticky", 256'(err_orphan), 256'(1'b1));
        rstn = 1'b0;
        #1;
        chk("orphan_cleared", 256'(err_orphan), 256'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/accum_slot_arbiter.md
ACCUM_SLOT_ARBITER -- requirements
Module: accum_slot_arbiter

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 2, number of requesting slots (slot0 = direct master, 1..N = routed).
REQ-002 SHALL have parameter NUM_BANKS, default 4, banks per zone and width of each mask.
REQ-003 SHALL have parameter ADDR_WIDTH, default 9, bank row address width.
REQ-004 SHALL have parameter DATA_WIDTH, default 64, per-bank data width.
REQ-005 SHALL have parameter RD_OUTSTANDING, default 4, depth of the read-return tag FIFO (power of two, >=2).
REQ-006 SHALL have ports as follows; one clock, reset asynchronous active-low:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
s_wr_valid / s_wr_ready  in / out  NUM_SLOTS  per-slot write handshake
s_wr_addr  in  NUM_SLOTS*ADDR_WIDTH  write row address
s_wr_mask  in  NUM_SLOTS*NUM_BANKS  write bank mask
s_accum_en  in  NUM_SLOTS  1 = accumulate, 0 = overwrite
s_wdata  in  NUM_SLOTS*NUM_BANKS*DATA_WIDTH  write data, same beat as command
s_rd_valid / s_rd_ready  in / out  NUM_SLOTS  per-slot read handshake
s_rd_addr  in  NUM_SLOTS*ADDR_WIDTH;  s_rd_mask  in  NUM_SLOTS*NUM_BANKS
s_rvalid  out  NUM_SLOTS  read-return strobe to owning slot
s_rdata  out  NUM_BANKS*DATA_WIDTH  read data, broadcast to all slots
m_wr_valid, m_wr_ready, m_wr_addr, m_wr_mask, m_accum_en, m_wdata  single-slot write channel to zone banks (valid/fields out, ready in)
m_rd_valid, m_rd_ready, m_rd_addr, m_rd_mask  single-slot read command channel to banks
m_rvalid  in  1;  m_rdata  in  NUM_BANKS*DATA_WIDTH  in-order bank read return
err_orphan  out  1  sticky: m_rvalid arrived with tag FIFO empty

Function
REQ-007 Write and read channels SHALL arbitrate independently, same cycle, zero-latency combinational grant.
REQ-008 Each channel SHALL use round-robin: search starts at its pointer; winner = first valid slot at or after pointer, wrapping.
REQ-009 Pointer SHALL update to (winner+1) mod NUM_SLOTS only on an accepted master handshake (m_*_valid & m_*_ready); held otherwise.
REQ-010 m_*_valid SHALL equal OR of eligible slot valids; m_* fields SHALL be the winner's fields; s_*_ready SHALL be 1 only for winner and only when m_*_ready=1.
REQ-011 A granted slot's fields SHALL stay selected while m_*_ready=0 (no re-arbitration until accept), provided its valid remains high.
REQ-012 Each accepted read SHALL push the winner slot index into the tag FIFO.
REQ-013 Read channel SHALL be ineligible (m_rd_valid=0, all s_rd_ready=0) when tag FIFO holds RD_OUTSTANDING entries, even if m_rvalid pops that cycle.
REQ-014 On m_rvalid with FIFO non-empty: s_rvalid[head]=1 same cycle, s_rdata=m_rdata, head popped.
REQ-015 Simultaneous push and pop SHALL leave occupancy unchanged.
REQ-016 On m_rvalid with FIFO empty: no s_rvalid, err_orphan set until reset.
REQ-017 Slot with NUM_SLOTS=1 SHALL degenerate to pass-through with tag tracking.

Reset
REQ-018 rstn low SHALL asynchronously clear both pointers to 0, FIFO to empty, err_orphan to 0, perf counters to 0.
REQ-019 During and after reset, s_rvalid SHALL be 0; reset mid-transaction SHALL discard outstanding tags (later m_rvalid flags err_orphan).

Configuration
REQ-020 With ACCUM_ARB_PERF_EN defined, SHALL add outputs perf_wr_grants and perf_rd_grants, NUM_SLOTS*32, per-slot saturating accepted-grant counters; without it, ports and counters SHALL not exist.

Structure
REQ-021 Slot-index type, mask/address/data typedefs SHALL live in accum_pkg, shared with zone and router.
REQ-022 Round-robin search SHALL be sub-module accum_rr_arbiter, instanced once per channel.

Verification
REQ-023 Slots 0,1 write-valid continuously, m_wr_ready=1 -> grants alternate 0,1,0,1; pointer wraps.
REQ-024 Slot1 valid, m_wr_ready=0 for 3 cycles then 1 -> m_wr_addr stable 3 cycles, s_wr_ready[1] pulses once, pointer moves to 0.
REQ-025 Four reads accepted (slots 0,1,1,0), m_rvalid withheld -> 5th read blocked; then 4 m_rvalid -> s_rvalid order 0,1,1,0.
REQ-026 FIFO full, m_rvalid and new read same cycle -> read not accepted that cycle, accepted next.
REQ-027 m_rvalid with empty FIFO -> no s_rvalid, err_orphan=1 until rstn low.
REQ-028 rstn asserted with 2 tags outstanding -> pointers 0, FIFO empty; with ACCUM_ARB_PERF_EN counters 0.
